alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the 8x8 reg_file and the combinational alu as a tiny execution unit. It accepts 16-bit instructions over a valid/ready handshake, then drives the reg_file read selects, alu op and write-back. It returns a result, a sticky zero flag and a retired-instruction count. It sits between an instruction source (testbench or fetch unit) and the reg_file/alu pair.

Parameters:
DATA_W, 8, datapath width; must match reg_file and alu.
ADDR_W, 3, register address width (8 registers).
CNT_W, 16, retired-instruction counter width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction available
instr  input  16  instruction word
instr_ready  output  1  controller can accept; high only in IDLE
resume  input  1  leave HALTED (level, sampled in HALTED)
rf_load  output  1  reg_file write enable
rf_sel_w  output  ADDR_W  reg_file write address
rf_d  output  DATA_W  reg_file write data
rf_sel_r1  output  ADDR_W  reg_file read address A
rf_sel_r2  output  ADDR_W  reg_file read address B
alu_op  output  3  alu operation select
alu_result  input  DATA_W  alu result
alu_zero  input  1  alu zero flag
done  output  1  one-cycle pulse per retired instruction
result  output  DATA_W  last written value
zero_flag  output  1  sticky zero from last ALU instruction
halted  output  1  controller in HALTED
retired  output  CNT_W  retired-instruction count, wraps

Behaviour:
- Instruction format:
  - [15:14] class: 00 ALU, 01 LOADI, 10 NOP, 11 HALT.
  - ALU: [13:11] op, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored.
  - LOADI: [10:8] rd, [7:0] imm, [13:11] ignored.
- Op codes pass through unchanged to the alu: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 shl, 111 shr. Results wrap mod 2^DATA_W.
- FSM states: IDLE, EXEC, WB, HALTED.
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs go to 0: rf_load, rf_sel_*, rf_d, alu_op, done, result, zero_flag, halted, retired.
  - instr_ready is 1 once reset deasserts.
  - A reset in any state aborts the current instruction; no rf_load is asserted after the reset edge.
- IDLE:
  - instr_ready=1. A transfer happens on a rising edge with instr_valid&&instr_ready. The instruction is latched into an internal register.
  - ALU goes to EXEC. LOADI goes to WB.
  - NOP stays in IDLE; done pulses and retired increments in the next cycle.
  - HALT goes to HALTED; done pulses and retired increments.
- EXEC (1 cycle):
  - rf_sel_r1=rs1, rf_sel_r2=rs2, alu_op=op, all driven from the latched register.
  - At end of cycle: result register <= alu_result, zero_flag <= alu_zero. Go to WB.
- WB (1 cycle):
  - rf_load=1, rf_sel_w=rd, rf_d = result register (ALU) or imm (LOADI). The write commits at the end of WB.
  - LOADI also sets result <= imm and leaves zero_flag unchanged.
  - Go to IDLE. done=1 and retired increments in the following cycle.
- Latency, ALU: accept edge N, EXEC cycle N+1, WB cycle N+2, done high in cycle N+3.
  - Back-to-back ALU throughput is one per 3 cycles.
  - Instructions reading the previous rd need no hazard handling, because the write commits before the next EXEC.
- Latency, LOADI: WB cycle N+1, done high in N+2.
- instr_ready=0 in EXEC, WB and HALTED. instr_valid may stay high and instr may change while ready is low; only the accepted word matters.
- HALTED: halted=1, instr_ready=0. resume=1 returns to IDLE on the next edge. A resume asserted outside HALTED is ignored.
- done is a registered single-cycle pulse. retired wraps from 2^CNT_W-1 to 0.
- rf_load is never high outside WB. rf_sel_*/alu_op hold their last values outside EXEC/WB.

Decomposition:
- Shared package alu_seq_pkg:
  - class encodings CLS_ALU/LOADI/NOP/HALT;
  - ALU op constants OP_ADD..OP_SHR (also used by alu);
  - FSM state encoding;
  - instruction field bit positions.
- No sub-module: a single FSM plus the instruction and result registers.
- Top level inverts reset for the active-high reg_file.

Test Plan:
- LOADI r0=0x0F, LOADI r1=0x03, then ALU add r2=r0+r1 -> rf_load pulse with rf_sel_w=2, rf_d=0x12; result=0x12, zero_flag=0, done three times, retired=3.
- ALU sub r3=r1-r1 after the loads -> rf_d=0x00, zero_flag=1. A following LOADI r4=0x00 leaves zero_flag=1 and sets result=0x00.
- Hold instr_valid high with an ALU instr then a LOADI -> second accepted exactly 3 cycles after the first. instr_ready low in EXEC/WB; no duplicate accept.
- HALT with instr_valid held high for 10 cycles -> halted=1, instr_ready=0, no rf_load, retired +1 only. Pulse resume -> IDLE next cycle, pending instr accepted.
- Drive reset=0 during EXEC of ALU xor r5 -> outputs zero immediately, rf_load never asserts, r5 unchanged on readback; after release instr_ready=1.
- CNT_W=4, issue 17 NOPs -> retired sequence 1..15, 0, 1; done pulses 17 times; no rf_load.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the alu_sequencer execution unit
// Instruction classes, ALU op codes, FSM states and instruction field positions.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOADI = 2'b01,
        CLS_NOP   = 2'b10,
        CLS_HALT  = 2'b11
    } cls_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_WB     = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    localparam int CLS_MSB = 15;
    localparam int CLS_LSB = 14;
    localparam int OP_MSB  = 13;
    localparam int OP_LSB  = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic cls_e cls_of(input logic [15:0] w);
        return cls_e'(w[CLS_MSB:CLS_LSB]);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller sequencing reg_file and alu
// Ports:
//   clk, reset (async, active-low)
//   instr_valid/instr/instr_ready : instruction handshake, ready only in IDLE
//   resume                        : leave HALTED
//   rf_load/rf_sel_w/rf_d         : reg_file write port (active only in WB)
//   rf_sel_r1/rf_sel_r2           : reg_file read selects (driven for EXEC)
//   alu_op, alu_result, alu_zero  : alu control and return
//   done, result, zero_flag, halted, retired : status
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              resume,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_sel_w,
    output logic [DATA_W-1:0] rf_d,
    output logic [ADDR_W-1:0] rf_sel_r1,
    output logic [ADDR_W-1:0] rf_sel_r2,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q;
    logic [15:0]       instr_q;
    logic              rf_load_q;
    logic [ADDR_W-1:0] rf_sel_w_q;
    logic [DATA_W-1:0] rf_d_q;
    logic [ADDR_W-1:0] rf_sel_r1_q;
    logic [ADDR_W-1:0] rf_sel_r2_q;
    logic [2:0]        alu_op_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              halted_q;
    logic [CNT_W-1:0]  retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            rf_load_q   <= 1'b0;
            rf_sel_w_q  <= '0;
            rf_d_q      <= '0;
            rf_sel_r1_q <= '0;
            rf_sel_r2_q <= '0;
            alu_op_q    <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            rf_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        case (cls_of(instr))
                            CLS_ALU: begin
                                // Read selects and op are registered here so they are stable for the whole EXEC cycle.
                                rf_sel_r1_q <= ADDR_W'(instr[RS1_MSB:RS1_LSB]);
                                rf_sel_r2_q <= ADDR_W'(instr[RS2_MSB:RS2_LSB]);
                                alu_op_q    <= instr[OP_MSB:OP_LSB];
                                state_q     <= ST_EXEC;
                            end
                            CLS_LOADI: begin
                                rf_load_q  <= 1'b1;
                                rf_sel_w_q <= ADDR_W'(instr[RD_MSB:RD_LSB]);
                                rf_d_q     <= DATA_W'(instr[IMM_MSB:IMM_LSB]);
                                state_q    <= ST_WB;
                            end
                            CLS_NOP: begin
                                done_q    <= 1'b1;
                                retired_q <= retired_q + CNT_W'(1);
                            end
                            default: begin
                                done_q    <= 1'b1;
                                retired_q <= retired_q + CNT_W'(1);
                                halted_q  <= 1'b1;
                                state_q   <= ST_HALTED;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    result_q   <= alu_result;
                    zero_q     <= alu_zero;
                    rf_load_q  <= 1'b1;
                    rf_sel_w_q <= ADDR_W'(instr_q[RD_MSB:RD_LSB]);
                    rf_d_q     <= alu_result;
                    state_q    <= ST_WB;
                end
                ST_WB: begin
                    // LOADI updates result but deliberately leaves zero_flag alone.
                    if (cls_of(instr_q) == CLS_LOADI) begin
                        result_q <= rf_d_q;
                    end
                    done_q    <= 1'b1;
                    retired_q <= retired_q + CNT_W'(1);
                    state_q   <= ST_IDLE;
                end
                ST_HALTED: begin
                    if (resume) begin
                        halted_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign rf_load     = rf_load_q;
    assign rf_sel_w    = rf_sel_w_q;
    assign rf_d        = rf_d_q;
    assign rf_sel_r1   = rf_sel_r1_q;
    assign rf_sel_r2   = rf_sel_r2_q;
    assign alu_op      = alu_op_q;
    assign done        = done_q;
    assign result      = result_q;
    assign zero_flag   = zero_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic          resume;
    logic          rf_load;
    logic [AW-1:0] rf_sel_w;
    logic [DW-1:0] rf_d;
    logic [AW-1:0] rf_sel_r1;
    logic [AW-1:0] rf_sel_r2;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          done;
    logic [DW-1:0] result;
    logic          zero_flag;
    logic          halted;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .resume(resume),
        .rf_load(rf_load), .rf_sel_w(rf_sel_w), .rf_d(rf_d),
        .rf_sel_r1(rf_sel_r1), .rf_sel_r2(rf_sel_r2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .done(done), .result(result), .zero_flag(zero_flag),
        .halted(halted), .retired(retired)
    );

    // Environment: 8x8 register file and combinational alu.
    logic [DW-1:0] rf_m [8] = '{default: 8'hAA};
    logic [DW-1:0] op_a, op_b;
    assign op_a = rf_m[rf_sel_r1];
    assign op_b = rf_m[rf_sel_r2];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = op_a + op_b;
            3'b001: alu_result = op_a - op_b;
            3'b010: alu_result = op_a & op_b;
            3'b011: alu_result = op_a | op_b;
            3'b100: alu_result = op_a ^ op_b;
            3'b101: alu_result = ~op_a;
            3'b110: alu_result = op_a << 1;
            default: alu_result = op_a >> 1;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    int            cyc = 0;
    int            acc_cyc[$];
    int            load_cnt = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_w_sel = '0;
    logic [DW-1:0] last_w_d = '0;

    always @(posedge clk) begin
        cyc++;
        if (instr_valid && instr_ready) acc_cyc.push_back(cyc);
        if (rf_load) begin
            load_cnt++;
            last_w_sel = rf_sel_w;
            last_w_d   = rf_d;
            rf_m[rf_sel_w] <= rf_d;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        bit ok;
        ok = 1'b0;
        instr_valid = 1'b1;
        instr       = w;
        for (int i = 0; i < 20; i++) begin
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_accept(input int n);
        for (int i = 0; i < 10 && acc_cyc.size() < n; i++) @(negedge clk);
        if (acc_cyc.size() < n) check("accept_timeout", acc_cyc.size(), n);
    endtask

    int n0, ld0, d0;

    initial begin
        reset = 1'b0; instr_valid = 1'b0; instr = '0; resume = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rf", {rf_load, rf_sel_w, rf_d, rf_sel_r1, rf_sel_r2, alu_op}, 0);
        check("rst_st", {done, result, zero_flag, halted, retired}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);

        // LOADI r0=0x0F, LOADI r1=0x03, add r2=r0+r1
        send(16'h400F);
        send(16'h4103);
        send(16'h0204);
        wait_done();
        check("add_wsel", last_w_sel, 2);
        check("add_wd", last_w_d, 8'h12);
        check("add_result", result, 8'h12);
        check("add_zero", zero_flag, 0);
        check("add_done_cnt", done_cnt, 3);
        check("add_retired", retired, 3);
        check("r0_val", rf_m[0], 8'h0F);

        // sub r3=r1-r1 then LOADI r4=0x00
        send(16'h0B24);
        wait_done();
        check("sub_r3", rf_m[3], 8'h00);
        check("sub_zero", zero_flag, 1);
        send(16'h4400);
        wait_done();
        check("ldi_zero_kept", zero_flag, 1);
        check("ldi_result", result, 8'h00);
        check("ldi_r4", rf_m[4], 8'h00);
        check("ldi_retired", retired, 5);

        // back-to-back: or r5=r0|r1 then LOADI r6=0x55 with valid held
        n0 = acc_cyc.size();
        instr_valid = 1'b1;
        instr = 16'h1D04;
        wait_accept(n0 + 1);
        instr = 16'h4655;
        check("exec_ready", instr_ready, 0);
        check("exec_sel", {rf_sel_r1, rf_sel_r2, alu_op}, {3'd0, 3'd1, 3'd3});
        check("exec_noload", rf_load, 0);
        @(negedge clk);
        check("wb_ready", instr_ready, 0);
        check("wb_write", {rf_load, rf_sel_w, rf_d}, {1'b1, 3'd5, 8'h0F});
        @(negedge clk);
        check("or_done", {done, instr_ready}, 2'b11);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("b2b_count", acc_cyc.size(), n0 + 2);
        if (acc_cyc.size() >= n0 + 2) check("b2b_gap", acc_cyc[n0+1] - acc_cyc[n0], 3);
        wait_done();
        check("r6_val", rf_m[6], 8'h55);
        check("r5_val", rf_m[5], 8'h0F);
        check("b2b_retired", retired, 7);

        // HALT with valid held, then resume
        n0 = acc_cyc.size();
        ld0 = load_cnt;
        instr_valid = 1'b1;
        instr = 16'hC000;
        wait_accept(n0 + 1);
        instr = 16'h473C;
        check("halt_enter", {halted, done}, 2'b11);
        repeat (10) @(negedge clk);
        check("halt_hold", {halted, instr_ready}, 2'b10);
        check("halt_noload", load_cnt, ld0);
        check("halt_retired", retired, 8);
        check("halt_noacc", acc_cyc.size(), n0 + 1);
        resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        @(negedge clk);
        check("resume_idle", {halted, instr_ready}, 2'b01);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("resume_acc", acc_cyc.size(), n0 + 2);
        wait_done();
        check("r7_val", rf_m[7], 8'h3C);
        check("resume_retired", retired, 9);

        // reset during EXEC of xor r5=r0^r1
        ld0 = load_cnt;
        send(16'h2504);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rf", {rf_load, rf_sel_w, rf_d, rf_sel_r1, rf_sel_r2, alu_op}, 0);
        check("mid_rst_st", {done, result, zero_flag, halted, retired}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_noload", load_cnt, ld0);
        check("mid_rst_r5", rf_m[5], 8'h0F);
        check("mid_rst_ready", instr_ready, 1);

        // 17 NOPs: retired wraps through 0
        d0 = done_cnt;
        ld0 = load_cnt;
        for (int k = 1; k <= 17; k++) begin
            send(16'h8000);
            @(negedge clk);
            check($sformatf("nop%0d", k), {done, retired}, {1'b1, 4'(k % 16)});
        end
        #1;
        check("nop_done_cnt", done_cnt, d0 + 17);
        check("nop_noload", load_cnt, ld0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
